// File: rtl/vrased_pkg.sv
// Shared constants for the VRASED violation reset sequencer: monitor indices,
// special cause codes and the sequencer state encoding.
package vrased_pkg;

    localparam int unsigned NUM_SRC = 6;

    localparam logic [2:0] SRC_XSTACK     = 3'd0;
    localparam logic [2:0] SRC_AC         = 3'd1;
    localparam logic [2:0] SRC_ATOMICITY  = 3'd2;
    localparam logic [2:0] SRC_DMA_AC     = 3'd3;
    localparam logic [2:0] SRC_DMA_DETECT = 3'd4;
    localparam logic [2:0] SRC_DMA_XSTACK = 3'd5;
    localparam logic [2:0] SRC_TIMEOUT    = 3'd6;
    localparam logic [2:0] SRC_NONE       = 3'd7;

    localparam logic [6:0] MASK_TIMEOUT = 7'h40;
    localparam logic [7:0] CNT_MAX      = 8'hFF;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ASSERT  = 2'd1,
        WAIT_PC = 2'd2
    } state_e;

endpackage

// File: rtl/vrased_prio_enc.sv
// Lowest-index-first priority encoder over the monitor violation flags;
// returns SRC_NONE when no flag is set.
module vrased_prio_enc
    import vrased_pkg::*;
(
    input  logic [NUM_SRC-1:0] vec_i,
    output logic [2:0]         idx_o
);

    // Scan from the top down so the lowest set bit is the last one written.
    always_comb begin
        idx_o = SRC_NONE;
        for (int unsigned i = NUM_SRC; i > 0; i--) begin
            if (vec_i[i-1]) begin
                idx_o = 3'(i - 1);
            end
        end
    end

endmodule

// File: rtl/vrased_reset_seq.sv
// VRASED violation reset sequencer: holds the MCU in reset after a monitor
// violation, supervises the reboot PC, and records causes for software.
module vrased_reset_seq
    import vrased_pkg::*;
#(
    parameter logic [15:0] RESET_HANDLER = 16'h0000,
    parameter logic [7:0]  HOLD_CYCLES   = 8'd4,
    parameter logic [15:0] BOOT_TIMEOUT  = 16'd64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] pc,
    input  logic [5:0]  viol,
    input  logic        cause_clr,
    output logic        sys_reset,
    output logic [2:0]  first_cause,
    output logic [6:0]  cause_mask,
    output logic [7:0]  viol_cnt,
    output logic        busy
);

    localparam logic [15:0] HOLD_LAST = {8'h00, HOLD_CYCLES} - 16'd1;
    localparam logic [15:0] BOOT_LAST = BOOT_TIMEOUT - 16'd1;

    state_e      state_q, state_d;
    logic [15:0] timer_q, timer_d;
    logic [2:0]  first_q, first_d;
    logic [6:0]  mask_q,  mask_d;
    logic [7:0]  cnt_q,   cnt_d;

    logic        viol_any;
    logic        entry;
    logic        timeout;
    logic [2:0]  enc_idx;
    logic [2:0]  first_base;
    logic [6:0]  mask_base;
    logic [7:0]  cnt_base;

    assign viol_any = |viol;

    vrased_prio_enc u_prio_enc (
        .vec_i (viol),
        .idx_o (enc_idx)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            timer_q <= '0;
            first_q <= SRC_NONE;
            mask_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            first_q <= first_d;
            mask_q  <= mask_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        entry   = 1'b0;
        timeout = 1'b0;
        case (state_q)
            IDLE: begin
                if (viol_any) begin
                    state_d = ASSERT;
                    entry   = 1'b1;
                end
            end
            ASSERT: begin
                if (timer_q == HOLD_LAST) begin
                    state_d = WAIT_PC;
                end
            end
            WAIT_PC: begin
                if (viol_any) begin
                    state_d = ASSERT;
                    entry   = 1'b1;
                end else if (pc == RESET_HANDLER) begin
                    state_d = IDLE;
                end else if (timer_q == BOOT_LAST) begin
                    state_d = ASSERT;
                    entry   = 1'b1;
                    timeout = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Timer restarts on any transition and idles at zero.
        if (state_d != state_q || state_q == IDLE) begin
            timer_d = '0;
        end else begin
            timer_d = timer_q + 16'd1;
        end
    end

    // A clear in the same cycle as an event wipes the old record first.
    always_comb begin
        first_base = cause_clr ? SRC_NONE : first_q;
        mask_base  = cause_clr ? 7'h00    : mask_q;
        cnt_base   = cause_clr ? 8'h00    : cnt_q;

        first_d = first_base;
        mask_d  = mask_base;
        cnt_d   = cnt_base;

        if (state_q == ASSERT) begin
            mask_d = mask_d | {1'b0, viol};
        end

        if (entry) begin
            mask_d = mask_d | (timeout ? MASK_TIMEOUT : {1'b0, viol});
            if (first_base == SRC_NONE) begin
                first_d = timeout ? SRC_TIMEOUT : enc_idx;
            end
            if (cnt_base != CNT_MAX) begin
                cnt_d = cnt_base + 8'd1;
            end
        end
    end

    assign sys_reset   = (state_q == ASSERT);
    assign busy        = (state_q != IDLE);
    assign first_cause = first_q;
    assign cause_mask  = mask_q;
    assign viol_cnt    = cnt_q;

endmodule

// File: tb/tb_vrased_reset_seq.sv
// Scoreboard bench for vrased_reset_seq: directed scenarios plus random
// traffic, checked each cycle against a countdown-based reference model.
module tb_vrased_reset_seq;

    localparam logic [15:0] RH   = 16'h0000;
    localparam int          HOLD = 4;
    localparam int          BT   = 5;
    localparam logic [15:0] PC_X = 16'h0100;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] pc;
    logic [5:0]  viol;
    logic        cause_clr;
    logic        sys_reset;
    logic [2:0]  first_cause;
    logic [6:0]  cause_mask;
    logic [7:0]  viol_cnt;
    logic        busy;

    vrased_reset_seq #(
        .RESET_HANDLER (RH),
        .HOLD_CYCLES   (8'(HOLD)),
        .BOOT_TIMEOUT  (16'(BT))
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .pc          (pc),
        .viol        (viol),
        .cause_clr   (cause_clr),
        .sys_reset   (sys_reset),
        .first_cause (first_cause),
        .cause_mask  (cause_mask),
        .viol_cnt    (viol_cnt),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       sr;
        logic [2:0] fc;
        logic [6:0] cm;
        logic [7:0] cnt;
        logic       bsy;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model: remaining hold / boot-wait cycles plus the records.
    int hold_left = 0;
    int wait_left = 0;
    int m_first   = 7;
    int m_mask    = 0;
    int m_cnt     = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int lowest(input logic [5:0] v);
        int r = 7;
        for (int i = 5; i >= 0; i--) if (v[i]) r = i;
        return r;
    endfunction

    task automatic model_reset();
        hold_left = 0;
        wait_left = 0;
        m_first   = 7;
        m_mask    = 0;
        m_cnt     = 0;
    endtask

    task automatic model_step(input logic [5:0] v, input logic [15:0] p, input logic c);
        bit enter = 0;
        bit tmo   = 0;
        if (c) begin
            m_first = 7;
            m_mask  = 0;
            m_cnt   = 0;
        end
        if (hold_left > 0) begin
            m_mask |= int'(v);
            hold_left--;
            if (hold_left == 0) wait_left = BT;
        end else if (wait_left > 0) begin
            if (v != 0)              enter = 1;
            else if (p == RH)        wait_left = 0;
            else if (wait_left == 1) begin enter = 1; tmo = 1; end
            else                     wait_left--;
        end else if (v != 0) begin
            enter = 1;
        end
        if (enter) begin
            wait_left = 0;
            hold_left = HOLD;
            if (m_cnt < 255) m_cnt++;
            m_mask |= tmo ? 'h40 : int'(v);
            if (m_first == 7) m_first = tmo ? 6 : lowest(v);
        end
    endtask

    function automatic exp_t model_out();
        exp_t e;
        e.sr  = (hold_left > 0);
        e.fc  = 3'(m_first);
        e.cm  = 7'(m_mask);
        e.cnt = 8'(m_cnt);
        e.bsy = (hold_left > 0) || (wait_left > 0);
        return e;
    endfunction

    // One clock of stimulus: drive, predict, queue the expected outputs.
    task automatic cyc(input logic [5:0] v, input logic [15:0] p, input logic c);
        viol      = v;
        pc        = p;
        cause_clr = c;
        model_step(v, p, c);
        sb.push_back(model_out());
        @(posedge clk);
        #3;
    endtask

    always begin
        exp_t e;
        @(posedge clk);
        #1;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check("sys_reset",   32'(sys_reset),   32'(e.sr));
            check("first_cause", 32'(first_cause), 32'(e.fc));
            check("cause_mask",  32'(cause_mask),  32'(e.cm));
            check("viol_cnt",    32'(viol_cnt),    32'(e.cnt));
            check("busy",        32'(busy),        32'(e.bsy));
        end
    end

    initial begin
        reset     = 1'b1;
        viol      = '0;
        pc        = PC_X;
        cause_clr = 1'b0;
        #1;
        check("rst_sys_reset",   32'(sys_reset),   32'd0);
        check("rst_first_cause", 32'(first_cause), 32'd7);
        check("rst_cause_mask",  32'(cause_mask),  32'd0);
        check("rst_viol_cnt",    32'(viol_cnt),    32'd0);
        check("rst_busy",        32'(busy),        32'd0);
        repeat (2) @(posedge clk);
        #3;
        reset = 1'b0;

        // Single atomicity pulse, clean reboot on the third WAIT_PC cycle.
        cyc(6'b000100, PC_X, 1'b0);
        repeat (HOLD) cyc('0, PC_X, 1'b0);
        repeat (2) cyc('0, PC_X, 1'b0);
        cyc('0, RH, 1'b0);
        check("t1_first", 32'(first_cause), 32'd2);
        check("t1_mask",  32'(cause_mask),  32'h04);
        check("t1_cnt",   32'(viol_cnt),    32'd1);
        check("t1_idle",  32'(busy),        32'd0);
        cyc('0, PC_X, 1'b1);

        // Multi-source entry, extra OR during hold, then boot timeout.
        cyc(6'b101010, PC_X, 1'b0);
        check("t2_first", 32'(first_cause), 32'd1);
        check("t2_mask",  32'(cause_mask),  32'h2A);
        cyc(6'b000001, PC_X, 1'b0);
        check("t2_mask_or", 32'(cause_mask), 32'h2B);
        check("t2_cnt",     32'(viol_cnt),   32'd1);
        repeat (HOLD - 1) cyc('0, PC_X, 1'b0);
        repeat (BT) cyc('0, PC_X, 1'b0);
        check("t3_sysrst", 32'(sys_reset),   32'd1);
        check("t3_mask",   32'(cause_mask),  32'h6B);
        check("t3_cnt",    32'(viol_cnt),    32'd2);
        check("t3_first",  32'(first_cause), 32'd1);
        repeat (HOLD) cyc('0, PC_X, 1'b0);
        cyc('0, RH, 1'b0);

        // Violation beats a PC match in WAIT_PC.
        cyc(6'b000001, PC_X, 1'b0);
        repeat (HOLD) cyc('0, PC_X, 1'b0);
        cyc(6'b000010, RH, 1'b0);
        check("t5_prio", 32'(sys_reset), 32'd1);
        repeat (HOLD) cyc('0, PC_X, 1'b0);
        cyc('0, RH, 1'b0);

        // Counter saturation, then clear colliding with a new entry.
        for (int i = 0; i < 256; i++) begin
            cyc(6'b000001, PC_X, 1'b0);
            repeat (HOLD) cyc('0, PC_X, 1'b0);
            cyc('0, RH, 1'b0);
        end
        check("t4_sat", 32'(viol_cnt), 32'd255);
        cyc(6'b001000, PC_X, 1'b1);
        check("t4_clr_cnt",   32'(viol_cnt),    32'd1);
        check("t4_clr_first", 32'(first_cause), 32'd3);
        check("t4_clr_mask",  32'(cause_mask),  32'h08);

        // Asynchronous reset in the middle of the hold.
        cyc('0, PC_X, 1'b0);
        reset = 1'b1;
        #1;
        check("t6_sys_reset", 32'(sys_reset),   32'd0);
        check("t6_first",     32'(first_cause), 32'd7);
        check("t6_mask",      32'(cause_mask),  32'd0);
        check("t6_cnt",       32'(viol_cnt),    32'd0);
        check("t6_busy",      32'(busy),        32'd0);
        model_reset();
        @(posedge clk);
        #3;
        reset = 1'b0;

        // Random traffic.
        for (int i = 0; i < 1500; i++) begin
            logic [5:0]  v;
            logic [15:0] p;
            logic        c;
            v = ($urandom_range(0, 7) == 0) ? 6'($urandom_range(1, 63)) : 6'd0;
            p = ($urandom_range(0, 3) == 0) ? RH : 16'($urandom_range(1, 65535));
            c = ($urandom_range(0, 31) == 0);
            cyc(v, p, c);
        end

        viol      = '0;
        cause_clr = 1'b0;
        repeat (2) @(posedge clk);
        #3;
        check("sb_drain", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
